// File: rtl/wm8731_vol_i2c_writer_if.sv
// Volume PIO input and open-drain I2C pad controls of the WM8731 volume writer.
interface wm8731_vol_i2c_writer_if;
    localparam int unsigned VOL_W = 7;

    logic [VOL_W-1:0] vol_in;
    logic             sda_in;
    logic             scl_oe;
    logic             sda_oe;
    logic             busy;
    logic             ack_err;
    logic [VOL_W-1:0] sent_vol;

    modport master (
        input  vol_in, sda_in,
        output scl_oe, sda_oe, busy, ack_err, sent_vol
    );

    modport slave (
        output vol_in, sda_in,
        input  scl_oe, sda_oe, busy, ack_err, sent_vol
    );
endinterface

// File: rtl/wm8731_vol_i2c_writer.sv
// Writes each new headphone volume to WM8731 LHPOUT (LRHPBOTH set) over open-drain I2C.
// Define VOL_ZC_EN to set LZCEN so the codec applies changes at a zero crossing.
module wm8731_vol_i2c_writer #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned I2C_HZ   = 100000,
    parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
    input logic                     clk,
    input logic                     reset_n,
    wm8731_vol_i2c_writer_if.master bus
);
    localparam int unsigned QDIV_RAW = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QDIV     = (QDIV_RAW < 2) ? 2 : QDIV_RAW;
    localparam int unsigned CNT_W    = $clog2(QDIV);
    localparam logic [7:0]  REG_BYTE = {7'h02, 1'b1};

`ifdef VOL_ZC_EN
    localparam logic ZC = 1'b1;
`else
    localparam logic ZC = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BYTE  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       phase;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [6:0]       last_req, cur_vol;
    logic             pending;
    logic             ack_sample, txn_nack;
    logic             sda_meta, sda_sync, sda_pre;
    logic             scl_oe, sda_oe, busy, ack_err;
    logic [6:0]       sent_vol;

    logic             tick_c, slot_end_c, start_c, tx_bit_c;
    logic             scl_low_c, sda_low_c;
    logic [7:0]       tx_byte_c;

    assign bus.scl_oe   = scl_oe;
    assign bus.sda_oe   = sda_oe;
    assign bus.busy     = busy;
    assign bus.ack_err  = ack_err;
    assign bus.sent_vol = sent_vol;

    assign tick_c     = (tick_cnt == CNT_W'(QDIV - 1));
    assign slot_end_c = tick_c && (phase == 2'd3);
    assign start_c    = (state == S_IDLE) && pending;

    always_comb begin
        case (byte_idx)
            2'd0:    tx_byte_c = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte_c = REG_BYTE;
            default: tx_byte_c = {ZC, cur_vol};
        endcase
    end

    assign tx_bit_c = tx_byte_c[bit_idx];

    // Next state and desired pad levels for the current slot phase.
    always_comb begin
        state_nxt = state;
        scl_low_c = 1'b0;
        sda_low_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) state_nxt = S_START;
            end
            S_START: begin
                sda_low_c = phase[1];
                if (slot_end_c) state_nxt = S_BYTE;
            end
            S_BYTE: begin
                scl_low_c = !phase[1];
                sda_low_c = !tx_bit_c;
                if (slot_end_c && (bit_idx == 3'd0)) state_nxt = S_ACK;
            end
            S_ACK: begin
                scl_low_c = !phase[1];
                if (slot_end_c) begin
                    state_nxt = (ack_sample || (byte_idx == 2'd2)) ? S_STOP : S_BYTE;
                end
            end
            S_STOP: begin
                scl_low_c = !phase[1];
                sda_low_c = (phase != 2'd3);
                if (slot_end_c) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (slot_end_c) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= bus.sda_in;
            sda_sync <= sda_meta;
        end
    end

    // Latching the live input at START coalesces a change landing in that same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_req <= 7'd0;
            pending  <= 1'b1;
            cur_vol  <= 7'd0;
        end else begin
            last_req <= bus.vol_in;
            if (start_c) begin
                pending <= 1'b0;
                cur_vol <= bus.vol_in;
            end else if (bus.vol_in != last_req) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            phase    <= 2'd0;
        end else if (state == S_IDLE) begin
            tick_cnt <= '0;
            phase    <= 2'd0;
        end else if (tick_c) begin
            tick_cnt <= '0;
            phase    <= phase + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx    <= 3'd7;
            byte_idx   <= 2'd0;
            ack_sample <= 1'b0;
            txn_nack   <= 1'b0;
            ack_err    <= 1'b0;
            sent_vol   <= 7'd0;
        end else begin
            if (start_c) begin
                bit_idx  <= 3'd7;
                byte_idx <= 2'd0;
                txn_nack <= 1'b0;
            end
            if ((state == S_BYTE) && slot_end_c) bit_idx <= bit_idx - 3'd1;
            if ((state == S_ACK) && tick_c && (phase == 2'd2)) ack_sample <= sda_sync;
            if ((state == S_ACK) && slot_end_c) begin
                byte_idx <= byte_idx + 2'd1;
                if (ack_sample) begin
                    ack_err  <= 1'b1;
                    txn_nack <= 1'b1;
                end
            end
            if ((state == S_STOP) && slot_end_c) begin
                sent_vol <= cur_vol;
                if (!txn_nack) ack_err <= 1'b0;
            end
        end
    end

    // SDA trails SCL by one clock to give hold time after each SCL fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            scl_oe  <= 1'b0;
            sda_pre <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            busy    <= (state_nxt != S_IDLE);
            scl_oe  <= scl_low_c;
            sda_pre <= sda_low_c;
            sda_oe  <= sda_pre;
        end
    end
endmodule

// File: tb/tb_wm8731_vol_i2c_writer.sv
// Directed bench for wm8731_vol_i2c_writer with an ACKing I2C slave model at 0x1A.
// Clock ratio gives QDIV=10, keeping every frame to 1200 clk.
module tb_wm8731_vol_i2c_writer;
    localparam int unsigned CLK_HZ = 4000000;
    localparam int unsigned I2C_HZ = 100000;
    localparam int QD         = 10;
    localparam int SLOT       = 4 * QD;
    localparam int FRAME      = 30 * SLOT;
    localparam int NACK_FRAME = 12 * SLOT;

`ifdef VOL_ZC_EN
    localparam logic [7:0] ZC_BIT = 8'h80;
`else
    localparam logic [7:0] ZC_BIT = 8'h00;
`endif

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic slave_low = 1'b0;
    logic nack_addr = 1'b0;
    logic sda_line;
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    wm8731_vol_i2c_writer_if bus ();

    assign sda_line   = !(bus.sda_oe || slave_low);
    assign bus.sda_in = sda_line;

    wm8731_vol_i2c_writer #(
        .CLK_HZ   (CLK_HZ),
        .I2C_HZ   (I2C_HZ),
        .DEV_ADDR (7'h1A)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave decoder plus SCL/SDA protocol monitor.
    logic       scl_now, sda_now;
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    logic       in_frame = 1'b0, period_ok = 1'b0, seen_50 = 1'b0;
    int         rise_cnt = 0, nbytes = 0, frames = 0, hl_cnt = 0;
    int         proto_viol = 0, timing_viol = 0, last_nbytes = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] rx [0:2];
    logic [7:0] lb0 = 8'h00, lb1 = 8'h00, lb2 = 8'h00;

    always @(negedge clk) begin
        scl_now = !bus.scl_oe;
        sda_now = sda_line;
        if (!reset_n) begin
            in_frame  = 1'b0;
            rise_cnt  = 0;
            slave_low = 1'b0;
            period_ok = 1'b0;
            hl_cnt    = 0;
        end else begin
            if (scl_now != scl_prev) begin
                if (period_ok && (hl_cnt < 2 * QD)) timing_viol++;
                period_ok = 1'b1;
                hl_cnt    = 1;
            end else begin
                hl_cnt++;
            end
            if (scl_now && scl_prev && sda_prev && !sda_now) begin
                if (in_frame) proto_viol++;
                in_frame = 1'b1;
                rise_cnt = 0;
                nbytes   = 0;
            end else if (scl_now && scl_prev && !sda_prev && sda_now) begin
                if (!in_frame || (rise_cnt != 1)) proto_viol++;
                in_frame    = 1'b0;
                frames++;
                last_nbytes = nbytes;
                lb0 = (nbytes > 0) ? rx[0] : 8'h00;
                lb1 = (nbytes > 1) ? rx[1] : 8'h00;
                lb2 = (nbytes > 2) ? rx[2] : 8'h00;
                if ((nbytes > 2) && ((rx[2] & 8'h7F) == 8'h50)) seen_50 = 1'b1;
            end else if (in_frame && scl_now && !scl_prev) begin
                if (rise_cnt < 8) shreg = {shreg[6:0], sda_now};
                rise_cnt++;
            end else if (in_frame && !scl_now && scl_prev) begin
                if (rise_cnt == 8) begin
                    if (nbytes < 3) rx[nbytes] = shreg;
                    nbytes++;
                    slave_low = !(nack_addr && (nbytes == 1));
                end else if (rise_cnt == 9) begin
                    slave_low = 1'b0;
                    rise_cnt  = 0;
                end
            end
        end
        scl_prev = scl_now;
        sda_prev = sda_now;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, output int at, output logic ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy === lvl) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic frame(input string tag, input int rise_budget, output int width);
        int   t_r, t_f;
        logic ok;
        wait_busy(1'b1, rise_budget, t_r, ok);
        check({tag, "_busy_rise"}, 32'(ok), 32'd1);
        wait_busy(1'b0, FRAME + 200, t_f, ok);
        check({tag, "_busy_fall"}, 32'(ok), 32'd1);
        width = t_f - t_r;
    endtask

    initial begin
        int   w, f0, t0, tr;
        logic ok;

        bus.vol_in = 7'h79;
        repeat (5) @(negedge clk);
        check("rst_scl_oe",   32'(bus.scl_oe),   32'd0);
        check("rst_sda_oe",   32'(bus.sda_oe),   32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_ack_err",  32'(bus.ack_err),  32'd0);
        check("rst_sent_vol", 32'(bus.sent_vol), 32'd0);

        // Power-up write of the initial volume.
        f0 = frames;
        reset_n = 1'b1;
        frame("boot", 5, w);
        check("boot_len",      32'(w),               32'(FRAME));
        check("boot_frames",   32'(frames - f0),     32'd1);
        check("boot_nbytes",   32'(last_nbytes),     32'd3);
        check("boot_b0",       32'(lb0),             32'h34);
        check("boot_b1",       32'(lb1),             32'h05);
        check("boot_b2",       32'(lb2),             32'(ZC_BIT | 8'h79));
        check("boot_sent_vol", 32'(bus.sent_vol),    32'h79);
        check("boot_ack_err",  32'(bus.ack_err),     32'd0);
        repeat (2 * SLOT) @(negedge clk);
        check("boot_single",   32'(frames - f0),     32'd1);
        check("boot_idle",     32'(bus.busy),        32'd0);

        // Change while idle.
        f0 = frames;
        bus.vol_in = 7'h60;
        t0 = cyc;
        wait_busy(1'b1, 2 + QD + 5, tr, ok);
        check("idle_chg_start", 32'(ok), 32'd1);
        check("idle_chg_lat_ok", 32'((tr - t0) <= 2 + QD), 32'd1);
        wait_busy(1'b0, FRAME + 200, w, ok);
        check("idle_chg_done",  32'(ok),             32'd1);
        check("idle_chg_b2",    32'(lb2),            32'(ZC_BIT | 8'h60));
        check("idle_chg_sent",  32'(bus.sent_vol),   32'h60);
        check("idle_chg_count", 32'(frames - f0),    32'd1);

        // Two changes during a frame coalesce into one follow-up write.
        f0 = frames;
        bus.vol_in = 7'h40;
        wait_busy(1'b1, 10, tr, ok);
        check("coal_start", 32'(ok), 32'd1);
        repeat (5 * SLOT) @(negedge clk);
        bus.vol_in = 7'h50;
        repeat (3 * SLOT) @(negedge clk);
        bus.vol_in = 7'h55;
        wait_busy(1'b0, FRAME + 200, w, ok);
        check("coal_first_done", 32'(ok),           32'd1);
        check("coal_first_b2",   32'(lb2),          32'(ZC_BIT | 8'h40));
        check("coal_first_sent", 32'(bus.sent_vol), 32'h40);
        frame("coal_second", 10, w);
        check("coal_second_len", 32'(w),            32'(FRAME));
        check("coal_second_b2",  32'(lb2),          32'(ZC_BIT | 8'h55));
        check("coal_second_sent", 32'(bus.sent_vol), 32'h55);
        repeat (2 * FRAME) @(negedge clk);
        check("coal_count",      32'(frames - f0),  32'd2);
        check("coal_no_50",      32'(seen_50),      32'd0);

        // Address NACK: short frame, sticky error, no retry.
        f0 = frames;
        nack_addr  = 1'b1;
        bus.vol_in = 7'h20;
        frame("nack", 10, w);
        check("nack_len",     32'(w),             32'(NACK_FRAME));
        check("nack_ack_err", 32'(bus.ack_err),   32'd1);
        check("nack_sent",    32'(bus.sent_vol),  32'h20);
        check("nack_nbytes",  32'(last_nbytes),   32'd1);
        check("nack_b0",      32'(lb0),           32'h34);
        repeat (2 * FRAME) @(negedge clk);
        check("nack_no_retry", 32'(frames - f0),  32'd1);
        check("nack_idle",     32'(bus.busy),     32'd0);
        nack_addr  = 1'b0;
        bus.vol_in = 7'h21;
        frame("nack_recover", 10, w);
        check("recover_len",     32'(w),            32'(FRAME));
        check("recover_ack_err", 32'(bus.ack_err),  32'd0);
        check("recover_sent",    32'(bus.sent_vol), 32'h21);

        // Reset during byte1 (bit5 slot, SCL and SDA both pulled low).
        bus.vol_in = 7'h33;
        wait_busy(1'b1, 10, tr, ok);
        check("abort_start", 32'(ok), 32'd1);
        repeat ((1 + 9 + 2) * SLOT + 5) @(negedge clk);
        check("abort_pre_scl", 32'(bus.scl_oe), 32'd1);
        check("abort_pre_sda", 32'(bus.sda_oe), 32'd1);
        f0 = frames;
        reset_n = 1'b0;
        #1;
        check("abort_scl_oe",   32'(bus.scl_oe),   32'd0);
        check("abort_sda_oe",   32'(bus.sda_oe),   32'd0);
        check("abort_busy",     32'(bus.busy),     32'd0);
        check("abort_sent_vol", 32'(bus.sent_vol), 32'd0);
        bus.vol_in = 7'h44;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        frame("after_abort", 5, w);
        check("after_abort_len",    32'(w),            32'(FRAME));
        check("after_abort_count",  32'(frames - f0),  32'd1);
        check("after_abort_nbytes", 32'(last_nbytes),  32'd3);
        check("after_abort_b2",     32'(lb2),          32'(ZC_BIT | 8'h44));
        check("after_abort_sent",   32'(bus.sent_vol), 32'h44);
        check("after_abort_ackerr", 32'(bus.ack_err),  32'd0);

        check("protocol_violations", 32'(proto_viol),  32'd0);
        check("scl_timing_violations", 32'(timing_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
